// File: rtl/arbiter_round_robin_binary_grant.sv
// Round-robin arbiter emitting a registered binary selector for an external mux.
// Grants are held until the output handshake; back-to-back transfers need no bubble.
module arbiter_round_robin_binary_grant #(
    parameter int INPUT_COUNT = 4,
    parameter int ADDR_WIDTH  = 2
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [INPUT_COUNT-1:0] requests_valid,
    output logic [INPUT_COUNT-1:0] requests_ready,
    output logic [ADDR_WIDTH-1:0]  selector,
    output logic                   grant_valid,
    input  logic                   grant_ready
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] GRANTED = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] LAST_INIT =
        ADDR_WIDTH'(INPUT_COUNT - 1);

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_selector;
    logic [ADDR_WIDTH-1:0] r_last;

    logic                  w_handshake;
    logic [ADDR_WIDTH-1:0] w_base;
    logic [ADDR_WIDTH-1:0] w_next;
    logic                  w_found;

    assign w_handshake = (r_state == GRANTED) && grant_ready;

    // On a handshake the source being served becomes the lowest priority.
    assign w_base = w_handshake ? r_selector : r_last;

    // Search base+1 .. base+INPUT_COUNT, wrapping at INPUT_COUNT.
    always_comb begin
        int v_idx;
        v_idx   = 0;
        w_found = 1'b0;
        w_next  = '0;
        for (int k = 1; k <= INPUT_COUNT; k++) begin
            v_idx = int'(w_base) + k;
            if (v_idx >= INPUT_COUNT) begin
                v_idx = v_idx - INPUT_COUNT;
            end
            if (!w_found && requests_valid[v_idx]) begin
                w_found = 1'b1;
                w_next  = v_idx[ADDR_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        requests_ready = '0;
        if (r_state == GRANTED) begin
            requests_ready[r_selector] = grant_ready;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state    <= IDLE;
            r_selector <= '0;
            r_last     <= LAST_INIT;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_selector <= w_next;
                        r_state    <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (grant_ready) begin
                        r_last <= r_selector;
                        if (w_found) begin
                            r_selector <= w_next;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign selector    = r_selector;
    assign grant_valid = (r_state == GRANTED);

endmodule

// File: tb/tb_arbiter_round_robin_binary_grant.sv
// Bench for the round-robin arbiter: directed scenarios plus a random
// run, both against a behavioural model, on 4-input and 3-input instances.
module tb_arbiter_round_robin_binary_grant;

    logic       clock;
    logic       clear;
    logic       grant_ready;
    logic [3:0] v4;
    logic [2:0] v3;
    logic [3:0] rdy4;
    logic [2:0] rdy3;
    logic [1:0] sel4;
    logic [1:0] sel3;
    logic       gv4;
    logic       gv3;

    int n_checks;
    int n_fail;

    int m_n     [2];
    int m_state [2];
    int m_sel   [2];
    int m_last  [2];
    int m_known;
    int exp_rdy [2];

    arbiter_round_robin_binary_grant #(
        .INPUT_COUNT(4),
        .ADDR_WIDTH (2)
    ) u_dut4 (
        .clock         (clock),
        .clear         (clear),
        .requests_valid(v4),
        .requests_ready(rdy4),
        .selector      (sel4),
        .grant_valid   (gv4),
        .grant_ready   (grant_ready)
    );

    arbiter_round_robin_binary_grant #(
        .INPUT_COUNT(3),
        .ADDR_WIDTH (2)
    ) u_dut3 (
        .clock         (clock),
        .clear         (clear),
        .requests_valid(v3),
        .requests_ready(rdy3),
        .selector      (sel3),
        .grant_valid   (gv3),
        .grant_ready   (grant_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input int n, input int base,
                                input logic [3:0] v);
        for (int k = 1; k <= n; k++) begin
            if (v[(base + k) % n]) return (base + k) % n;
        end
        return -1;
    endfunction

    // Drive one cycle: check outputs against the model, then advance it.
    task automatic cycle(input logic [3:0] a4, input logic [2:0] a3,
                         input logic gr, input logic clr);
        logic [3:0] vv [2];
        int p;
        int ns [2];
        int nsel [2];
        int nl [2];
        v4 = a4;
        v3 = a3;
        grant_ready = gr;
        clear = clr;
        vv[0] = a4;
        vv[1] = {1'b0, a3};
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_rdy[d] = m_state[d] != 0 ? (int'(gr) << m_sel[d]) : 0;
        end
        if (m_known != 0) begin
            check("gv4", 32'(gv4), 32'(m_state[0]));
            check("sel4", 32'(sel4), 32'(m_sel[0]));
            check("rdy4", 32'(rdy4), 32'(exp_rdy[0]));
            check("gv3", 32'(gv3), 32'(m_state[1]));
            check("sel3", 32'(sel3), 32'(m_sel[1]));
            check("rdy3", 32'(rdy3), 32'(exp_rdy[1]));
            check("sel3_range", 32'(sel3 < 2'd3), 32'd1);
        end
        for (int d = 0; d < 2; d++) begin
            ns[d] = m_state[d];
            nsel[d] = m_sel[d];
            nl[d] = m_last[d];
            if (clr) begin
                ns[d] = 0;
                nsel[d] = 0;
                nl[d] = m_n[d] - 1;
            end else if (m_state[d] == 0) begin
                p = pick(m_n[d], m_last[d], vv[d]);
                if (p >= 0) begin
                    ns[d] = 1;
                    nsel[d] = p;
                end
            end else if (gr) begin
                nl[d] = m_sel[d];
                p = pick(m_n[d], m_sel[d], vv[d]);
                if (p >= 0) nsel[d] = p;
                else ns[d] = 0;
            end
        end
        @(posedge clock);
        for (int d = 0; d < 2; d++) begin
            m_state[d] = ns[d];
            m_sel[d] = nsel[d];
            m_last[d] = nl[d];
        end
        if (clr) m_known = 1;
        @(negedge clock);
    endtask

    task automatic expect4(input string tag, input int s, input int g,
                           input int r);
        #1;
        check({tag, "_sel"}, 32'(sel4), 32'(s));
        check({tag, "_gv"}, 32'(gv4), 32'(g));
        check({tag, "_rdy"}, 32'(rdy4), 32'(r));
    endtask

    initial begin
        logic [3:0] r4;
        logic [2:0] r3;
        n_checks = 0;
        n_fail = 0;
        m_n[0] = 4;
        m_n[1] = 3;
        m_known = 0;
        for (int d = 0; d < 2; d++) begin
            m_state[d] = 0;
            m_sel[d] = 0;
            m_last[d] = 0;
            exp_rdy[d] = 0;
        end
        clear = 1'b1;
        grant_ready = 1'b0;
        v4 = '0;
        v3 = '0;
        @(negedge clock);

        // reset, then a single requester is re-granted every cycle
        cycle(4'b0000, 3'b000, 1'b1, 1'b1);
        expect4("reset", 0, 0, 0);
        cycle(4'b0100, 3'b000, 1'b1, 1'b0);
        expect4("single", 2, 1, 4'b0100);
        cycle(4'b0100, 3'b000, 1'b1, 1'b0);
        expect4("single_re", 2, 1, 4'b0100);

        // fairness with everyone requesting
        cycle(4'b0000, 3'b000, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            cycle(4'b1111, 3'b000, 1'b1, 1'b0);
            expect4("fair", k % 4, 1, 1 << (k % 4));
        end

        // backpressure holds the grant
        cycle(4'b0000, 3'b000, 1'b0, 1'b1);
        cycle(4'b0010, 3'b000, 1'b0, 1'b0);
        expect4("bp_grant", 1, 1, 0);
        cycle(4'b0010, 3'b000, 1'b0, 1'b0);
        cycle(4'b0011, 3'b000, 1'b0, 1'b0);
        cycle(4'b1011, 3'b000, 1'b0, 1'b0);
        cycle(4'b1011, 3'b000, 1'b0, 1'b0);
        cycle(4'b1011, 3'b000, 1'b0, 1'b0);
        expect4("bp_hold", 1, 1, 0);
        cycle(4'b1011, 3'b000, 1'b1, 1'b0);
        expect4("bp_next", 3, 1, 4'b1000);

        // drain to idle, selector holds
        cycle(4'b0000, 3'b000, 1'b1, 1'b1);
        cycle(4'b1000, 3'b000, 1'b1, 1'b0);
        expect4("drain_grant", 3, 1, 4'b1000);
        cycle(4'b0000, 3'b000, 1'b1, 1'b0);
        expect4("drain_idle", 3, 0, 0);
        cycle(4'b0001, 3'b000, 1'b1, 1'b0);
        expect4("drain_new", 0, 1, 4'b0001);

        // three inputs: wrap at 3, never 3
        cycle(4'b0000, 3'b000, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cycle(4'b0000, 3'b111, 1'b1, 1'b0);
            #1;
            check("np2_sel", 32'(sel3), 32'(k % 3));
            check("np2_gv", 32'(gv3), 32'd1);
        end

        // clear while a grant is pending
        cycle(4'b0000, 3'b000, 1'b0, 1'b1);
        cycle(4'b0100, 3'b000, 1'b0, 1'b0);
        expect4("mid_grant", 2, 1, 0);
        cycle(4'b0110, 3'b000, 1'b0, 1'b1);
        expect4("mid_clear", 0, 0, 0);
        cycle(4'b0110, 3'b000, 1'b0, 1'b0);
        expect4("mid_regrant", 1, 1, 0);

        // random traffic honouring valid-until-ready
        cycle(4'b0000, 3'b000, 1'b0, 1'b1);
        r4 = '0;
        r3 = '0;
        for (int k = 0; k < 400; k++) begin
            r4 = (r4 & ~exp_rdy[0][3:0]) | 4'($urandom_range(0, 15));
            r3 = (r3 & ~exp_rdy[1][2:0]) | 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                r4 = r4 & ~exp_rdy[0][3:0];
                r3 = r3 & ~exp_rdy[1][2:0];
            end
            cycle(r4, r3, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 63) == 0));
        end
        cycle(4'b0000, 3'b000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arbiter_round_robin_binary_grant.md
Name: arbiter_round_robin_binary_grant

Overview:
- Round-robin arbiter over INPUT_COUNT valid/ready source channels.
- Produces the registered binary selector that directly drives a downstream binary multiplexer's `selector` input. The payload from `words_in` is muxed externally.
- Holds each grant until the output handshake completes. Supports back-to-back transfers at full throughput.

Parameters:
- INPUT_COUNT, 4, number of source channels (>= 2).
- ADDR_WIDTH, 2, selector width; must satisfy 2**ADDR_WIDTH >= INPUT_COUNT.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- clear  input  1  synchronous, active-high reset.
- requests_valid  input  INPUT_COUNT  bit i = source i offers a word.
- requests_ready  output  INPUT_COUNT  bit i = source i's word is accepted this cycle.
- selector  output  ADDR_WIDTH  binary index of the granted source; registered output.
- grant_valid  output  1  muxed output word is valid; registered output.
- grant_ready  input  1  downstream accepts the muxed word.

Behaviour:
- Reset (clear=1 at an edge):
  - selector=0, grant_valid=0, requests_ready=0.
  - Internal last_granted = INPUT_COUNT-1, so source 0 has top priority after reset.
  - clear has priority over all other events, including a handshake in the same cycle.
- States:
  - IDLE (grant_valid=0).
  - GRANTED (grant_valid=1).
- Priority order: search starts at last_granted+1 and wraps modulo INPUT_COUNT. last_granted is lowest priority.
- IDLE:
  - If any requests_valid bit is set, register the first requester in priority order into selector. Go to GRANTED next cycle.
  - Latency from request to grant_valid is 1 cycle.
  - If no request, stay in IDLE; selector holds its last value.
- GRANTED:
  - requests_ready[selector] = grant_ready. All other requests_ready bits = 0. This path is combinational.
  - Handshake occurs when grant_ready=1: last_granted <= selector.
  - On handshake, if any requests_valid bit is set in that same cycle, pick the next grant in the updated priority order. Load it into selector and stay GRANTED. No bubble.
  - The requester just served counts only if it still asserts valid, and it comes last in the order. A sole requester is therefore re-granted every cycle.
  - On handshake with no request, go to IDLE and deassert grant_valid.
  - With grant_ready=0: selector and grant_valid are held stable. A grant is never revoked or switched.
- Protocol on sources: once requests_valid[i] rises it stays high until requests_ready[i]. If the granted source drops valid anyway, the grant is still held until the handshake; this is an upstream violation and the bench need not cover it.
- Selector values >= INPUT_COUNT are never produced.
- requests_ready never has more than one bit set. It is all-zero in IDLE and during reset.
- Arithmetic: pointer increment wraps at INPUT_COUNT, not at 2**ADDR_WIDTH. This must hold for non-power-of-two INPUT_COUNT (e.g. 3).
- Mid-operation clear: a pending grant is dropped with no handshake. Sources keep valid high and are re-arbitrated from source 0.

Test Plan:
- Reset then single request: clear 1 cycle; requests_valid=0b0100, grant_ready=1.
  - Next cycle: selector=2, grant_valid=1, requests_ready=0b0100.
  - Source 2 is re-granted every cycle while valid stays high.
- Fairness, all requesting: requests_valid=0b1111, grant_ready=1 constantly.
  - selector sequence is 0,1,2,3,0,1 with one handshake per cycle and no bubbles.
- Backpressure: grant to source 1, grant_ready=0 for 5 cycles while requests_valid changes 0b0010 -> 0b1011.
  - selector stays 1 and grant_valid stays 1 throughout.
  - After grant_ready=1 the next selector is 3.
- Drain to idle: single request on source 3, handshake, then requests_valid=0.
  - grant_valid=0 on the next cycle; selector remains 3.
  - A new request on 0b0001 yields selector=0 after 1 cycle.
- Non-power-of-two: INPUT_COUNT=3, ADDR_WIDTH=2, all valid.
  - selector cycles 0,1,2,0 and never shows 3.
- Mid-grant clear: GRANTED on source 2 with grant_ready=0; assert clear.
  - Next cycle: grant_valid=0, requests_ready=0.
  - With 0b0110 still valid, the first grant after release is selector=1.
